// File: rtl/backend_gain_cal_ctrl.sv
// Resets the analog backend, shifts a 5-bit gain word out MSB first, waits for ready and samples vco1_fast;
// sweep mode repeats this for all 32 codes. A run lasts ~RST+11*SCLK_DIV+wait cycles per code; i_start is ignored while busy.
module backend_gain_cal_ctrl #(
  parameter int unsigned SCLK_DIV    = 4,
  parameter int unsigned RST_CYCLES  = 3,
  parameter int unsigned RDY_TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_resetAll,
  input  logic        i_start,
  input  logic        i_sweep,
  input  logic [4:0]  i_gain_word,
  input  logic        i_ready,
  input  logic        i_vco1_fast,
  output logic        o_resetbAll,
  output logic        o_sclk,
  output logic        o_sdin,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic        o_result_valid,
  output logic [4:0]  o_result_code,
  output logic        o_result_fast,
  output logic        o_found,
  output logic [31:0] o_fast_map
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SHIFT, S_WAIT, S_SAMPLE, S_NEXT, S_DONE
  } state_t;

  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SCLK_LAST = 16'(SCLK_DIV - 1);
  localparam logic [15:0] TO_LAST   = 16'(RDY_TIMEOUT - 1);
  localparam logic [3:0]  PH_LAST   = 4'd10;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  phase_q, phase_d;
  logic [4:0]  code_q, code_d;
  logic        sweep_q, sweep_d;
  logic        rstb_q, rstb_d;
  logic        sclk_q, sclk_d;
  logic        sdin_q, sdin_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        rvalid_q, rvalid_d;
  logic [4:0]  rcode_q, rcode_d;
  logic        rfast_q, rfast_d;
  logic        found_q, found_d;
  logic [31:0] map_q, map_d;
  logic [2:0]  bit_idx;

  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      code_q    <= '0;
      sweep_q   <= 1'b0;
      rstb_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdin_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rcode_q   <= '0;
      rfast_q   <= 1'b0;
      found_q   <= 1'b0;
      map_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      code_q    <= code_d;
      sweep_q   <= sweep_d;
      rstb_q    <= rstb_d;
      sclk_q    <= sclk_d;
      sdin_q    <= sdin_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rvalid_q  <= rvalid_d;
      rcode_q   <= rcode_d;
      rfast_q   <= rfast_d;
      found_q   <= found_d;
      map_q     <= map_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    code_d    = code_q;
    sweep_d   = sweep_q;
    timeout_d = timeout_q;
    rvalid_d  = rvalid_q;
    rcode_d   = rcode_q;
    rfast_d   = rfast_q;
    found_d   = found_q;
    map_d     = map_q;
    bit_idx   = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          sweep_d   = i_sweep;
          code_d    = i_sweep ? 5'd0 : i_gain_word;
          timeout_d = 1'b0;
          rvalid_d  = 1'b0;
          found_d   = 1'b0;
          if (i_sweep) map_d = '0;
          cnt_d     = '0;
          state_d   = S_RST;
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          phase_d = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SHIFT: begin
        // Even phases are sclk-low, odd phases sclk-high; phase 10 is the trailing low.
        if (cnt_q == SCLK_LAST) begin
          cnt_d = '0;
          if (phase_q == PH_LAST) state_d = S_WAIT;
          else                    phase_d = phase_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (i_ready) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SAMPLE: begin
        if (!sweep_q) begin
          rcode_d = code_q;
          rfast_d = i_vco1_fast;
          state_d = S_DONE;
        end else begin
          map_d[code_q] = i_vco1_fast;
          if (!i_vco1_fast && !found_q) begin
            found_d = 1'b1;
            rcode_d = code_q;
            rfast_d = 1'b0;
          end
          if (code_q == 5'd31) begin
            state_d = S_DONE;
            // Publish the not-found result together with the done pulse.
            if (!found_d) begin
              rcode_d = 5'd31;
              rfast_d = 1'b1;
            end
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        code_d  = code_q + 5'd1;
        cnt_d   = '0;
        state_d = S_RST;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) rvalid_d = 1'b1;

    // Serial outputs are registered from next-state values so they never glitch.
    rstb_d = (state_d != S_RST);
    done_d = (state_d == S_DONE);
    sclk_d = (state_d == S_SHIFT) && phase_d[0];
    sdin_d = 1'b0;
    if (state_d == S_SHIFT && phase_d != PH_LAST) begin
      bit_idx = 3'd4 - phase_d[3:1];
      sdin_d  = code_d[bit_idx];
    end
  end

  assign o_resetbAll    = rstb_q;
  assign o_sclk         = sclk_q;
  assign o_sdin         = sdin_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = done_q;
  assign o_timeout      = timeout_q;
  assign o_result_valid = rvalid_q;
  assign o_result_code  = rcode_q;
  assign o_result_fast  = rfast_q;
  assign o_found        = found_q;
  assign o_fast_map     = map_q;

endmodule

// File: tb/tb_backend_gain_cal_ctrl.sv
// Directed bench for backend_gain_cal_ctrl with a behavioural backend that deserialises the gain word.
module tb_backend_gain_cal_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_sweep = 1'b0;
  logic [4:0]  i_gain_word = 5'd0;
  logic        i_ready = 1'b0;
  logic        i_vco1_fast = 1'b0;
  logic        o_resetbAll, o_sclk, o_sdin, o_busy, o_done, o_timeout;
  logic        o_result_valid, o_result_fast, o_found;
  logic [4:0]  o_result_code;
  logic [31:0] o_fast_map;

  int total = 0;
  int bad   = 0;

  backend_gain_cal_ctrl dut (
    .i_clk(clk), .i_resetAll(rst), .i_start(i_start), .i_sweep(i_sweep),
    .i_gain_word(i_gain_word), .i_ready(i_ready), .i_vco1_fast(i_vco1_fast),
    .o_resetbAll(o_resetbAll), .o_sclk(o_sclk), .o_sdin(o_sdin), .o_busy(o_busy),
    .o_done(o_done), .o_timeout(o_timeout), .o_result_valid(o_result_valid),
    .o_result_code(o_result_code), .o_result_fast(o_result_fast),
    .o_found(o_found), .o_fast_map(o_fast_map)
  );

  always #5 clk = ~clk;

  // Backend model: cleared by o_resetbAll, shifts sdin on rising sclk, raises ready
  // rdy_delay cycles after the fifth bit; fast = (captured word < thresh).
  int         rdy_en = 1, rdy_delay = 40, thresh = 32;
  int         m_bits = 0, m_wait = 0, m_passes = 0;
  logic [4:0] m_word = 5'd0;
  logic       m_sclk_prev = 1'b0, m_rstb_prev = 1'b0;
  logic [4:0] words_q[$];

  always @(negedge clk) begin
    if (!o_resetbAll) begin
      if (m_rstb_prev) m_passes++;
      m_bits = 0; m_word = 5'd0; m_wait = 0;
    end else if (o_sclk && !m_sclk_prev && m_bits < 5) begin
      m_word = {m_word[3:0], o_sdin};
      m_bits++;
      if (m_bits == 5) words_q.push_back(m_word);
    end else if (m_bits == 5) begin
      m_wait++;
    end
    m_sclk_prev = o_sclk;
    m_rstb_prev = o_resetbAll;
    i_ready     = (rdy_en != 0) && (m_bits == 5) && (m_wait >= rdy_delay);
    i_vco1_fast = (int'(m_word) < thresh);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic sweep, input logic [4:0] w);
    i_start = 1'b1; i_sweep = sweep; i_gain_word = w;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < limit && !ok) begin
      tick(); n++;
      if (o_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (o_resetbAll !== 1'b0) begin bad++; $display("FAIL reset_rstb_held got=%b want=0", o_resetbAll); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_held got=%b want=0", o_busy); end
    rst = 1'b0;
    #1;
    total++; if (o_resetbAll !== 1'b0) begin bad++; $display("FAIL release_rstb_before_clk got=%b want=0", o_resetbAll); end
    tick();
    total++; if (o_resetbAll !== 1'b1) begin bad++; $display("FAIL release_rstb_after_clk got=%b want=1", o_resetbAll); end
    total++;
    if ({o_sclk, o_sdin, o_busy, o_done, o_timeout, o_result_valid, o_result_fast, o_found} !== 8'h00 ||
        o_result_code !== 5'd0 || o_fast_map !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got sclk=%b sdin=%b busy=%b done=%b to=%b rv=%b rc=%0d rf=%b fnd=%b map=%h want all 0",
               o_sclk, o_sdin, o_busy, o_done, o_timeout, o_result_valid, o_result_code, o_result_fast, o_found, o_fast_map);
    end
  endtask

  task automatic test_single();
    int n; bit ok;
    rdy_en = 1; rdy_delay = 40; thresh = 32;
    words_q.delete();
    start_run(1'b0, 5'b10110);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", o_busy); end
    n = 0;
    while (o_resetbAll == 1'b0 && n < 20) begin n++; tick(); end
    total++; if (n != 3) begin bad++; $display("FAIL single_rst_len got=%0d want=3", n); end
    wait_done(2000, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done_timeout got=no_done want=done"); end
    total++; if (m_bits != 5 || m_word !== 5'b10110) begin bad++; $display("FAIL single_sdin_bits got=%b (%0d bits) want=10110", m_word, m_bits); end
    total++; if (o_result_code !== 5'd22 || o_result_fast !== 1'b1) begin bad++; $display("FAIL single_result got=%0d/%b want=22/1", o_result_code, o_result_fast); end
    total++; if (o_result_valid !== 1'b1 || o_timeout !== 1'b0) begin bad++; $display("FAIL single_flags got rv=%b to=%b want rv=1 to=0", o_result_valid, o_timeout); end
    tick();
    total++; if (o_done !== 1'b0 || o_busy !== 1'b0 || o_result_valid !== 1'b1) begin bad++; $display("FAIL single_after got done=%b busy=%b rv=%b want 0/0/1", o_done, o_busy, o_result_valid); end
  endtask

  task automatic test_sweep_found();
    int n; bit ok; bit seq_ok;
    rdy_en = 1; rdy_delay = 2; thresh = 13;
    words_q.delete(); m_passes = 0;
    start_run(1'b1, 5'd9);
    wait_done(8000, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL sweep_found_done_timeout got=no_done want=done"); end
    total++; if (o_fast_map !== 32'h00001FFF) begin bad++; $display("FAIL sweep_found_map got=%h want=00001fff", o_fast_map); end
    total++; if (o_found !== 1'b1 || o_result_code !== 5'd13 || o_result_fast !== 1'b0) begin bad++; $display("FAIL sweep_found_result got fnd=%b rc=%0d rf=%b want 1/13/0", o_found, o_result_code, o_result_fast); end
    seq_ok = (words_q.size() == 32);
    for (int k = 0; k < words_q.size(); k++) if (words_q[k] !== 5'(k)) seq_ok = 1'b0;
    total++; if (!seq_ok || m_passes != 32) begin bad++; $display("FAIL sweep_found_passes got words=%0d resets=%0d want 32 in order/32", words_q.size(), m_passes); end
    tick();
  endtask

  task automatic test_sweep_none();
    int n; bit ok;
    rdy_en = 1; rdy_delay = 2; thresh = 32;
    start_run(1'b1, 5'd0);
    wait_done(8000, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL sweep_none_done_timeout got=no_done want=done"); end
    total++; if (o_fast_map !== 32'hFFFFFFFF) begin bad++; $display("FAIL sweep_none_map got=%h want=ffffffff", o_fast_map); end
    total++; if (o_found !== 1'b0 || o_result_code !== 5'd31 || o_result_fast !== 1'b1 || o_result_valid !== 1'b1) begin bad++; $display("FAIL sweep_none_result got fnd=%b rc=%0d rf=%b rv=%b want 0/31/1/1", o_found, o_result_code, o_result_fast, o_result_valid); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    rdy_en = 0; thresh = 32;
    start_run(1'b0, 5'b00011);
    total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL timeout_rv_cleared got=%b want=0", o_result_valid); end
    n = 0;
    while (!o_timeout && n < 3000) begin tick(); n++; end
    total++; if (n != 3 + 44 + 1023) begin bad++; $display("FAIL timeout_latency got=%0d want=%0d", n, 3 + 44 + 1023); end
    total++; if (o_done !== 1'b1 || o_result_valid !== 1'b1) begin bad++; $display("FAIL timeout_done got done=%b rv=%b want 1/1", o_done, o_result_valid); end
    total++; if (o_result_code !== 5'd31 || o_result_fast !== 1'b1) begin bad++; $display("FAIL timeout_result_kept got=%0d/%b want=31/1", o_result_code, o_result_fast); end
    tick();
    total++; if (o_timeout !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL timeout_sticky got to=%b busy=%b done=%b want 1/0/0", o_timeout, o_busy, o_done); end
    rdy_en = 1;
  endtask

  task automatic test_reset_mid_run();
    int n; bit ok;
    rdy_en = 1; rdy_delay = 2; thresh = 13;
    words_q.delete();
    start_run(1'b1, 5'd0);
    n = 0;
    while (words_q.size() < 7 && n < 5000) begin tick(); n++; end
    while (o_resetbAll && n < 5100) begin tick(); n++; end
    while (!o_resetbAll && n < 5200) begin tick(); n++; end
    total++; if (n >= 5000) begin bad++; $display("FAIL midrun_reach_code7 got cycles=%0d want <5000", n); end
    repeat (10) tick();
    start_run(1'b0, 5'd3);
    tick();
    total++; if (o_busy !== 1'b1 || o_resetbAll !== 1'b1 || o_fast_map[6:0] !== 7'h7F) begin bad++; $display("FAIL midrun_start_ignored got busy=%b rstb=%b map=%h want 1/1/..7f", o_busy, o_resetbAll, o_fast_map); end
    rst = 1'b1;
    #1;
    total++;
    if (o_busy !== 1'b0 || o_resetbAll !== 1'b0 || o_sclk !== 1'b0 || o_fast_map !== 32'h0 ||
        o_found !== 1'b0 || o_timeout !== 1'b0 || o_result_code !== 5'd0) begin
      bad++;
      $display("FAIL midrun_async_reset got busy=%b rstb=%b sclk=%b map=%h fnd=%b to=%b rc=%0d want 0s", o_busy, o_resetbAll, o_sclk, o_fast_map, o_found, o_timeout, o_result_code);
    end
    tick();
    rst = 1'b0;
    tick();
    total++; if (o_resetbAll !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL midrun_release got rstb=%b busy=%b want 1/0", o_resetbAll, o_busy); end
    words_q.delete();
    start_run(1'b1, 5'd17);
    wait_done(8000, n, ok);
    total++; if (!ok || words_q.size() != 32 || words_q[0] !== 5'd0) begin bad++; $display("FAIL midrun_restart got done=%0d words=%0d want done, 32 words from code 0", ok, words_q.size()); end
    total++; if (o_result_code !== 5'd13 || o_found !== 1'b1) begin bad++; $display("FAIL midrun_restart_result got=%0d/%b want=13/1", o_result_code, o_found); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep_found();
    test_sweep_none();
    test_timeout();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
